// File: rtl/gnt_lock4.sv
// -----------------------------------------------------------------------------
// gnt_lock4
//
// Grant lock and burst controller that sits directly behind a 4-way rotating
// priority selector. While idle it samples the selector's one-hot grant. The
// winner is locked as owner of the shared resource for a burst of (len field +
// 1) beats. The selector enable is held low until the burst completes or the
// owner withdraws its request. One gap cycle follows every burst so that the
// selector's rotation counter advances cleanly before the next arbitration.
//
// Ports
//   clock     in   system clock, all state changes on the rising edge
//   reset     in   synchronous active-low reset
//   req       in   [3:0] raw request lines, used to detect owner withdrawal
//   gnt_in    in   [3:0] selector grant, one-hot or zero expected
//   len       in   [4*BURST_W-1:0] per-requester burst length fields
//   ready     in   downstream accepts the current beat
//   arb_en    out  selector enable, high only while idle
//   owner     out  [3:0] one-hot locked owner, zero when nothing is locked
//   owner_id  out  [1:0] binary index of the owner, zero when nothing is locked
//   valid     out  beat presented downstream (busy only)
//   remain    out  [BURST_W-1:0] beats remaining after the current one
//   last      out  valid and remain == 0
//   done      out  one-cycle pulse in the gap after a completed burst
//   abort     out  one-cycle pulse in the gap after an abandoned burst
//   err       out  sticky flag, multi-hot grant seen while idle
// -----------------------------------------------------------------------------
module gnt_lock4 #(
    parameter int BURST_W = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [3:0]             req,
    input  logic [3:0]             gnt_in,
    input  logic [4*BURST_W-1:0]   len,
    input  logic                   ready,
    output logic                   arb_en,
    output logic [3:0]             owner,
    output logic [1:0]             owner_id,
    output logic                   valid,
    output logic [BURST_W-1:0]     remain,
    output logic                   last,
    output logic                   done,
    output logic                   abort,
    output logic                   err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t              state_q,    state_d;
    logic [3:0]          owner_q,    owner_d;
    logic [1:0]          owner_id_q, owner_id_d;
    logic [BURST_W-1:0]  remain_q,   remain_d;
    logic                done_q,     done_d;
    logic                abort_q,    abort_d;
    logic                err_q,      err_d;

    // Per-requester view of the packed length bus.
    logic [BURST_W-1:0]  len_field [4];

    for (genvar gi = 0; gi < 4; gi++) begin : g_len
        assign len_field[gi] = len[gi*BURST_W +: BURST_W];
    end

    // Population count and encoded index of the incoming grant. The index is
    // only meaningful when exactly one bit is set.
    logic [2:0] gnt_cnt;
    logic [1:0] gnt_idx;

    always_comb begin
        gnt_cnt = '0;
        gnt_idx = '0;
        for (int i = 0; i < 4; i++) begin
            if (gnt_in[i]) begin
                gnt_cnt = gnt_cnt + 3'd1;
                gnt_idx = 2'(i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        owner_id_d = owner_id_q;
        remain_d   = remain_q;
        done_d     = 1'b0;
        abort_d    = 1'b0;
        err_d      = err_q;

        case (state_q)
            ST_IDLE: begin
                if (gnt_cnt == 3'd1) begin
                    owner_d    = gnt_in;
                    owner_id_d = gnt_idx;
                    remain_d   = len_field[gnt_idx];
                    state_d    = ST_BUSY;
                end else if (gnt_cnt > 3'd1) begin
                    err_d = 1'b1;
                end
            end

            ST_BUSY: begin
                // Completion is checked first so that a withdrawal on the
                // accepted last beat still counts as a finished burst.
                if (ready && (remain_q == '0)) begin
                    done_d  = 1'b1;
                    state_d = ST_GAP;
                end else if (!req[owner_id_q]) begin
                    // Beat offered in this cycle is discarded, remain holds.
                    abort_d = 1'b1;
                    state_d = ST_GAP;
                end else if (ready) begin
                    remain_d = remain_q - BURST_W'(1);
                end
            end

            ST_GAP: begin
                owner_d    = '0;
                owner_id_d = '0;
                remain_d   = '0;
                state_d    = ST_IDLE;
            end

            default: begin
                owner_d    = '0;
                owner_id_d = '0;
                remain_d   = '0;
                state_d    = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            owner_q    <= '0;
            owner_id_q <= '0;
            remain_q   <= '0;
            done_q     <= 1'b0;
            abort_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            owner_id_q <= owner_id_d;
            remain_q   <= remain_d;
            done_q     <= done_d;
            abort_q    <= abort_d;
            err_q      <= err_d;
        end
    end

    // All outputs are decodes of registered state only.
    assign arb_en   = (state_q == ST_IDLE);
    assign valid    = (state_q == ST_BUSY);
    assign last     = (state_q == ST_BUSY) && (remain_q == '0);
    assign owner    = owner_q;
    assign owner_id = owner_id_q;
    assign remain   = remain_q;
    assign done     = done_q;
    assign abort    = abort_q;
    assign err      = err_q;

endmodule

// File: tb/tb_gnt_lock4.sv
// -----------------------------------------------------------------------------
// tb_gnt_lock4
//
// Directed scenarios followed by a randomized run. A behavioural model tracks
// the owner as an integer index and the remaining beats as an integer, and is
// stepped on every rising edge with the same inputs the design sees. Outputs
// are compared on the falling edge.
// -----------------------------------------------------------------------------
module tb_gnt_lock4;

    localparam int BW = 4;

    logic            clock = 1'b0;
    logic            reset;
    logic [3:0]      req;
    logic [3:0]      gnt_in;
    logic [4*BW-1:0] len;
    logic            ready;
    logic            arb_en;
    logic [3:0]      owner;
    logic [1:0]      owner_id;
    logic            valid;
    logic [BW-1:0]   remain;
    logic            last;
    logic            done;
    logic            abort;
    logic            err;

    gnt_lock4 #(.BURST_W(BW)) dut (
        .clock    (clock),
        .reset    (reset),
        .req      (req),
        .gnt_in   (gnt_in),
        .len      (len),
        .ready    (ready),
        .arb_en   (arb_en),
        .owner    (owner),
        .owner_id (owner_id),
        .valid    (valid),
        .remain   (remain),
        .last     (last),
        .done     (done),
        .abort    (abort),
        .err      (err)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // m_mode: 0 = waiting for a grant, 1 = burst in progress, 2 = gap cycle
    int m_mode   = 0;
    int m_owner  = -1;   // requester index, -1 when nothing is locked
    int m_remain = 0;
    int m_pulse  = 0;    // 0 none, 1 completed, 2 abandoned
    bit m_err    = 0;

    function automatic int field_of(input logic [4*BW-1:0] l, input int i);
        return int'((l >> (i*BW)) & 16'hF);
    endfunction

    task automatic model_step();
        int ones;
        int idx;
        if (!reset) begin
            m_mode = 0; m_owner = -1; m_remain = 0; m_pulse = 0; m_err = 0;
            return;
        end
        if (m_mode == 0) begin
            m_pulse = 0;
            ones = 0; idx = 0;
            for (int i = 0; i < 4; i++) if (gnt_in[i]) begin ones++; idx = i; end
            if (ones == 1) begin
                m_owner = idx; m_remain = field_of(len, idx); m_mode = 1;
            end else if (ones > 1) begin
                m_err = 1;
            end
        end else if (m_mode == 1) begin
            if (ready && m_remain == 0) begin
                m_mode = 2; m_pulse = 1;
            end else if (!req[m_owner]) begin
                m_mode = 2; m_pulse = 2;
            end else begin
                if (ready) m_remain = m_remain - 1;
                m_pulse = 0;
            end
        end else begin
            m_mode = 0; m_owner = -1; m_remain = 0; m_pulse = 0;
        end
    endtask

    task automatic check_all();
        chk("arb_en",   {31'd0, arb_en}, (m_mode == 0) ? 1 : 0);
        chk("valid",    {31'd0, valid},  (m_mode == 1) ? 1 : 0);
        chk("owner",    {28'd0, owner},  (m_owner < 0) ? 0 : (1 << m_owner));
        chk("owner_id", {30'd0, owner_id}, (m_owner < 0) ? 0 : m_owner);
        chk("remain",   {28'd0, remain}, m_remain);
        chk("last",     {31'd0, last},   (m_mode == 1 && m_remain == 0) ? 1 : 0);
        chk("done",     {31'd0, done},   (m_mode == 2 && m_pulse == 1) ? 1 : 0);
        chk("abort",    {31'd0, abort},  (m_mode == 2 && m_pulse == 2) ? 1 : 0);
        chk("err",      {31'd0, err},    m_err ? 1 : 0);
        if (m_mode == 2)
            $display("burst owner=%0d %s", m_owner, (m_pulse == 1) ? "done" : "abort");
    endtask

    // Advance one clock: model follows the rising edge, outputs checked on the
    // falling edge, new inputs are driven by the caller after return.
    task automatic tick();
        @(posedge clock);
        model_step();
        @(negedge clock);
        check_all();
    endtask

    initial begin
        int rcnt;
        bit seen;
        int r;

        reset = 1'b0; req = '0; gnt_in = '0; len = '0; ready = 1'b0;

        // Reset for two cycles, then idle with no grant.
        tick(); tick();
        reset = 1'b1;
        tick(); tick();
        chk("rst_arb_en", {31'd0, arb_en}, 1);
        chk("rst_owner",  {28'd0, owner},  0);
        chk("rst_valid",  {31'd0, valid},  0);

        // Requester 2, four beats, ready held.
        len = 16'h0300; req = 4'b0100; gnt_in = 4'b0100; ready = 1'b1;
        tick();
        gnt_in = '0;
        for (int k = 0; k < 4; k++) begin
            chk("d2_remain",   {28'd0, remain},   3 - k);
            chk("d2_last",     {31'd0, last},     (k == 3) ? 1 : 0);
            chk("d2_owner_id", {30'd0, owner_id}, 2);
            tick();
        end
        chk("d2_done", {31'd0, done}, 1);
        tick();
        chk("d2_arb_en", {31'd0, arb_en}, 1);

        // Same lock with ready toggling.
        gnt_in = 4'b0100;
        tick();
        gnt_in = '0;
        rcnt = 0; seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            ready = (i % 2 == 0);
            if (valid && ready) rcnt++;
            tick();
            if (done) seen = 1;
        end
        chk("d3_done_seen", {31'd0, seen}, 1);
        chk("d3_ready_beats", rcnt, 4);
        ready = 1'b1;
        tick();

        // Requester 1, six beats, withdrawn after two.
        len = 16'h0050; req = 4'b0010; gnt_in = 4'b0010;
        tick();
        gnt_in = '0;
        tick(); tick();
        req = '0;
        tick();
        chk("d4_abort", {31'd0, abort}, 1);
        chk("d4_done",  {31'd0, done},  0);
        tick();
        chk("d4_arb_en", {31'd0, arb_en}, 1);
        chk("d4_remain", {28'd0, remain}, 0);

        // Withdrawal on the accepted last beat completes normally.
        len = 16'h0010; req = 4'b0010; gnt_in = 4'b0010;
        tick();
        gnt_in = '0;
        tick();
        req = '0;
        tick();
        chk("d4b_done",  {31'd0, done},  1);
        chk("d4b_abort", {31'd0, abort}, 0);
        tick();

        // Multi-hot grant sets err, then a normal lock of requester 0.
        req = 4'b0011; gnt_in = 4'b0011; len = 16'h0002;
        tick();
        chk("d5_err",   {31'd0, err},   1);
        chk("d5_valid", {31'd0, valid}, 0);
        gnt_in = 4'b0001;
        tick();
        gnt_in = '0;
        chk("d5_owner", {28'd0, owner}, 4'b0001);
        chk("d5_err2",  {31'd0, err},   1);
        for (int i = 0; i < 10 && !arb_en; i++) tick();
        chk("d5_back_idle", {31'd0, arb_en}, 1);

        // Reset in the middle of a burst.
        len = 16'h4000; req = 4'b1000; gnt_in = 4'b1000;
        tick();
        gnt_in = '0;
        tick(); tick();
        chk("d6_remain", {28'd0, remain}, 2);
        reset = 1'b0;
        tick();
        chk("d6_valid",  {31'd0, valid},  0);
        chk("d6_arb_en", {31'd0, arb_en}, 1);
        chk("d6_owner",  {28'd0, owner},  0);
        chk("d6_pulse",  {30'd0, done, abort}, 0);
        reset = 1'b1;
        tick();

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            r = int'($urandom_range(0, 7));
            if (r < 3)      gnt_in = '0;
            else if (r < 7) gnt_in = 4'b0001 << $urandom_range(0, 3);
            else            gnt_in = 4'($urandom);
            req   = ($urandom_range(0, 11) == 0) ? 4'($urandom) : 4'hF;
            ready = ($urandom_range(0, 3) != 0);
            len   = 16'($urandom);
            reset = ($urandom_range(0, 199) != 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
